// File: rtl/sync_ram_arb.sv
// Two-port round-robin arbiter in front of a single-port synchronous-read RAM.
// Each port tracks at most one outstanding read through an IDLE/LIVE/HELD response FSM.
module sync_ram_arb #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [AWIDTH-1:0] req0_addr,
  input  logic [DWIDTH-1:0] req0_wdata,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DWIDTH-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [AWIDTH-1:0] req1_addr,
  input  logic [DWIDTH-1:0] req1_wdata,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DWIDTH-1:0] rsp1_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_d,
  input  logic [DWIDTH-1:0] ram_q
);

  typedef enum logic [1:0] {StIdle, StLive, StHeld} rsp_state_e;

  rsp_state_e        state_q [2];
  rsp_state_e        state_d [2];
  logic [DWIDTH-1:0] buf_q   [2];
  logic [DWIDTH-1:0] buf_d   [2];
  logic [DWIDTH-1:0] rdata   [2];
  logic              ptr_q, ptr_d;

  logic [1:0] valid, we, rsp_rdy, rsp_vld, elig, gnt, rd_acc;

  assign valid   = {req1_valid, req0_valid};
  assign we      = {req1_we, req0_we};
  assign rsp_rdy = {rsp1_ready, rsp0_ready};

  // A read is only eligible when its response slot is free or draining this cycle.
  always_comb begin
    rsp_vld = 2'b00;
    elig    = 2'b00;
    for (int i = 0; i < 2; i++) begin
      rsp_vld[i] = (state_q[i] != StIdle);
      elig[i]    = valid[i] & (we[i] | (state_q[i] == StIdle) | (rsp_vld[i] & rsp_rdy[i]));
    end
  end

  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      if (elig[0] && (!elig[1] || !ptr_q)) begin
        gnt[0] = 1'b1;
      end else if (elig[1]) begin
        gnt[1] = 1'b1;
      end
    end
  end

  assign rd_acc     = gnt & ~we;
  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign ram_en     = |gnt;
  assign ram_we     = gnt[1] ? req1_we    : req0_we;
  assign ram_addr   = gnt[1] ? req1_addr  : req0_addr;
  assign ram_d      = gnt[1] ? req1_wdata : req0_wdata;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt[0]) begin
      ptr_d = 1'b1;
    end else if (gnt[1]) begin
      ptr_d = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      buf_d[i]   = buf_q[i];
      rdata[i]   = '0;
      case (state_q[i])
        StIdle: begin
          if (rd_acc[i]) state_d[i] = StLive;
        end
        StLive: begin
          rdata[i] = ram_q;
          if (rsp_rdy[i]) begin
            state_d[i] = rd_acc[i] ? StLive : StIdle;
          end else begin
            // ram_q may be overwritten by the other port's next access; park it.
            buf_d[i]   = ram_q;
            state_d[i] = StHeld;
          end
        end
        StHeld: begin
          rdata[i] = buf_q[i];
          if (rsp_rdy[i]) state_d[i] = rd_acc[i] ? StLive : StIdle;
        end
        default: state_d[i] = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= StIdle;
        buf_q[i]   <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        buf_q[i]   <= buf_d[i];
      end
    end
  end

  assign rsp0_valid = rsp_vld[0];
  assign rsp1_valid = rsp_vld[1];
  assign rsp0_rdata = rdata[0];
  assign rsp1_rdata = rdata[1];

endmodule

// File: doc/sync_ram_arb.md
SYNC_RAM_ARB -- requirements
Module: sync_ram_arb

Interface
REQ-001 SHALL have parameter DWIDTH, default 8: data width, matches the attached single-port synchronous-read RAM.
REQ-002 SHALL have parameter AWIDTH, default 8: address width, matches the attached RAM.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have, for i in {0,1}, port req<i>_valid  input  1  requester i presents an access.
REQ-006 SHALL have port req<i>_ready  output  1  access accepted this cycle when valid and ready are both high.
REQ-007 SHALL have port req<i>_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req<i>_addr  input  AWIDTH  access address.
REQ-009 SHALL have port req<i>_wdata  input  DWIDTH  write data.
REQ-010 SHALL have port rsp<i>_valid  output  1  read data available to requester i.
REQ-011 SHALL have port rsp<i>_ready  input  1  requester i takes the response this cycle.
REQ-012 SHALL have port rsp<i>_rdata  output  DWIDTH  read data.
REQ-013 SHALL have ports ram_en, ram_we (output 1), ram_addr (output AWIDTH), ram_d (output DWIDTH): RAM enable, write-enable, address, write data.
REQ-014 SHALL have port ram_q  input  DWIDTH  RAM read data, valid one cycle after an enabled access and held until the next enabled access.

Function
REQ-015 SHALL grant at most one access per cycle; ram_en = 1 exactly in the cycles where an access is accepted.
REQ-016 SHALL drive ram_we/ram_addr/ram_d combinationally from the granted requester's req<i>_we/addr/wdata; when ram_en = 0 these are don't-care, and the bench SHALL check them only when ram_en = 1.
REQ-017 SHALL compute req<i>_ready combinationally: high only if port i is eligible and the arbiter grants it.
REQ-018 Port i is eligible when req<i>_valid = 1 and, for a read, the response slot of port i is IDLE or is being consumed this cycle (rsp<i>_valid and rsp<i>_ready both high). Writes are always eligible.
REQ-019 SHALL use round-robin: a 1-bit priority pointer selects the preferred port; if both ports are eligible, the preferred port wins; if one port is eligible, it wins.
REQ-020 After any grant to port i, the pointer SHALL move to 1-i; with no grant the pointer holds.
REQ-021 Writes SHALL produce no response.
REQ-022 Each port SHALL allow at most one outstanding read.
REQ-023 Each port SHALL run a response FSM: IDLE, LIVE, HELD.
REQ-024 Response FSM transition: IDLE -> LIVE on a read accepted at cycle N; the FSM is LIVE at N+1.
REQ-025 In LIVE: rsp<i>_valid = 1 and rsp<i>_rdata = ram_q (1-cycle read latency).
REQ-026 Response FSM transitions out of LIVE: if rsp<i>_ready = 1, go to IDLE, or to LIVE if a new read is accepted in the same cycle; otherwise capture ram_q into a per-port DWIDTH buffer and go to HELD.
REQ-027 In HELD: rsp<i>_valid = 1 and rsp<i>_rdata = buffer. The buffer SHALL be immune to later RAM accesses by either port.
REQ-028 Response FSM transition out of HELD: if rsp<i>_ready = 1, go to IDLE, or to LIVE if a new read is accepted in the same cycle.
REQ-029 In IDLE: rsp<i>_valid = 0 and rsp<i>_rdata = 0.
REQ-030 A write at cycle N followed by a read of the same address at N+1 or later SHALL return the written data.
REQ-031 Requests from both ports to the same address in one cycle SHALL be serialized in round-robin order without corruption.
REQ-032 req<i>_valid dropping without acceptance SHALL be legal and leave no state behind.

Reset
REQ-033 While rst = 1: both response FSMs IDLE, both rsp<i>_valid = 0, both req<i>_ready = 0, ram_en = 0, pointer = port 0, buffers = 0.
REQ-034 Asserting rst mid-operation SHALL discard any LIVE/HELD response immediately; RAM contents are unaffected.
REQ-035 The first clock edge after rst deasserts SHALL allow grants.

Verification
REQ-036 Write then read: port 0 writes 0xA5 to address 0x10, then reads 0x10 -> rsp0_valid = 1 one cycle after read acceptance, rsp0_rdata = 0xA5.
REQ-037 Contention: both ports hold valid reads continuously, rsp ready held high -> grants alternate 0,1,0,1; each rsp valid for one cycle after its own grant.
REQ-038 Backpressure: port 1 reads address 0x20 (contents 0x3C), rsp1_ready = 0 for 4 cycles while port 0 writes 0xFF to 0x20 -> rsp1_rdata stays 0x3C in HELD; port 1 read requests are not accepted until rsp1_ready = 1.
REQ-039 Back-to-back: port 0 reads consecutive addresses 0..7 with rsp0_ready = 1 and port 1 idle -> one accept per cycle; responses are in order with latency 1.
REQ-040 Reset mid-operation: rst pulses while rsp0 is HELD -> rsp0_valid = 0 asynchronously; first grant after release goes to port 0 when both ports are requesting.
